// File: rtl/noc_pkg.sv
// Shared NoC types, geometry constants and route helpers for the router input ports.
package noc;

    localparam int unsigned DataWidth      = 64;
    localparam int unsigned PortQueueDepth = 4;
    localparam int unsigned xMax           = 8;
    localparam int unsigned yMax           = 8;
    localparam int unsigned xWidth         = $clog2(xMax);
    localparam int unsigned yWidth         = $clog2(yMax);

    typedef struct packed {
        logic [xWidth-1:0] x;
        logic [yWidth-1:0] y;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef enum logic [4:0] {
        goNorth = 5'b00001,
        goEast  = 5'b00010,
        goSouth = 5'b00100,
        goWest  = 5'b01000,
        goLocal = 5'b10000
    } direction_t;

    typedef enum logic [2:0] {
        kNorthPort = 3'd0,
        kEastPort  = 3'd1,
        kSouthPort = 3'd2,
        kWestPort  = 3'd3,
        kLocalPort = 3'd4
    } noc_port_t;

    typedef enum logic {
        kFlowControlAckNack     = 1'b0,
        kFlowControlCreditBased = 1'b1
    } noc_flow_control_t;

    // Destination sits directly below the preamble and the source coordinates.
    function automatic xy_t get_dest(input logic [DataWidth-1:0] flit);
        return flit[DataWidth-3-$bits(xy_t) -: $bits(xy_t)];
    endfunction

    function automatic direction_t xy_route(input xy_t pos, input xy_t dest);
        direction_t dir;
        if (dest.x > pos.x) begin
            dir = goEast;
        end else if (dest.x < pos.x) begin
            dir = goWest;
        end else if (dest.y > pos.y) begin
            dir = goSouth;
        end else if (dest.y < pos.y) begin
            dir = goNorth;
        end else begin
            dir = goLocal;
        end
        return dir;
    endfunction

    function automatic direction_t port_dir(input noc_port_t port);
        direction_t dir;
        case (port)
            kNorthPort: dir = goNorth;
            kEastPort:  dir = goEast;
            kSouthPort: dir = goSouth;
            kWestPort:  dir = goWest;
            default:    dir = goLocal;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/noc_input_unit_fifo.sv
// Circular flit buffer; pointers wrap at Depth so any depth 2..16 works.
// Callers only assert push_i when there is room (or a pop frees it) and pop_i when non-empty.
module noc_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic [DataWidth-1:0]       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == CntWidth'(0));
    assign count_o = count_q;

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: flit queue, ack/nack or credit flow control, XY routing
// with the route held for the whole packet once its head has been granted.
module noc_input_unit #(
    parameter int unsigned             DataWidth   = noc::DataWidth,
    parameter int unsigned             Depth       = noc::PortQueueDepth,
    parameter noc::noc_flow_control_t  FlowControl = noc::kFlowControlCreditBased,
    parameter noc::noc_port_t          InPort      = noc::kLocalPort
) (
    input  logic                 clk,
    input  logic                 rst,
    input  noc::xy_t             position,
    input  logic [DataWidth-1:0] data_in,
    input  logic                 data_void_in,
    output logic                 stop_out,
    output logic                 credit_out,
    output logic [DataWidth-1:0] flit_out,
    output logic                 flit_valid,
    output noc::direction_t      route_out,
    input  logic                 pop,
    output logic                 overflow_err,
    output logic                 route_err
);
    import noc::*;

    localparam int unsigned CreditsWidth = $clog2(Depth + 1);
    localparam int unsigned XyBits       = $bits(xy_t);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q;
    direction_t              route_q, route_s, calc_route_s;
    xy_t                     dest_s;
    logic [DataWidth-1:0]    fifo_data_s;
    logic [CreditsWidth-1:0] count_s, count_next_s;
    logic full_s, empty_s, push_ok_s, pop_ok_s, overflow_s, uturn_s;
    logic head_s, tail_s, stop_q, credit_q, overflow_q, route_err_q;

    noc_fifo #(.Depth(Depth), .DataWidth(DataWidth)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok_s),
        .pop_i   (pop_ok_s),
        .data_i  (data_in),
        .data_o  (fifo_data_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // A pop on a full queue frees the slot the concurrent push lands in.
    always_comb begin
        pop_ok_s     = pop && !empty_s;
        push_ok_s    = !data_void_in && (!full_s || pop_ok_s);
        overflow_s   = !data_void_in && full_s && !pop_ok_s;
        count_next_s = count_s;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_s + CreditsWidth'(1);
            2'b01:   count_next_s = count_s - CreditsWidth'(1);
            default: count_next_s = count_s;
        endcase
    end

    // Route selection for the flit at the head of the queue.
    always_comb begin
        head_s       = fifo_data_s[DataWidth-1];
        tail_s       = fifo_data_s[DataWidth-2];
        dest_s       = fifo_data_s[DataWidth-3-XyBits -: XyBits];
        calc_route_s = xy_route(position, dest_s);
        if (state_q == LOCKED) begin
            route_s = route_q;
        end else if (empty_s || !head_s) begin
            route_s = goLocal;
        end else begin
            route_s = calc_route_s;
        end
        uturn_s = (state_q == IDLE) && !empty_s && (!head_s || (calc_route_s == port_dir(InPort)));
    end

    // Packet FSM: hold the head's route until its tail is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= goLocal;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_ok_s && head_s && !tail_s) begin
                        state_q <= LOCKED;
                        route_q <= calc_route_s;
                    end
                end
                LOCKED: begin
                    if (pop_ok_s && tail_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flow-control strobes and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q      <= 1'b0;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            route_err_q <= 1'b0;
        end else begin
            stop_q      <= (FlowControl == kFlowControlAckNack) &&
                           (count_next_s >= CreditsWidth'(Depth - 1));
            credit_q    <= (FlowControl == kFlowControlCreditBased) && pop_ok_s;
            overflow_q  <= overflow_q | overflow_s;
            route_err_q <= route_err_q | uturn_s;
        end
    end

    assign stop_out     = stop_q;
    assign credit_out   = credit_q;
    assign flit_out     = fifo_data_s;
    assign flit_valid   = !empty_s;
    assign route_out    = route_s;
    assign overflow_err = overflow_q;
    assign route_err    = route_err_q;

endmodule
